// File: rtl/uart9_slave_rx_buffer.sv
// Receive buffer for a 9-bit multidrop UART slave: address filter plus FIFO.
// Optional macro UART9_BROADCAST_EN: an all-ones address also selects.
module uart9_slave_rx_buffer #(
    parameter int                DATA_W     = 8,
    parameter int                DEPTH      = 8,
    parameter logic [DATA_W-1:0] SLAVE_ADDR = DATA_W'(5)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W:0]            rx_word,
    input  logic                       rx_valid,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       selected,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, SELECTED} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] payload;
    logic              is_addr;
    logic              is_data;
    logic              addr_hit;
    logic              bcast;
    logic              push;
    logic              pop;
    logic              drop;

    assign payload = rx_word[DATA_W-1:0];
    assign is_addr = rx_valid & rx_word[DATA_W];
    assign is_data = rx_valid & ~rx_word[DATA_W];

`ifdef UART9_BROADCAST_EN
    assign bcast = &payload;
`else
    assign bcast = 1'b0;
`endif

    assign addr_hit = (payload == SLAVE_ADDR) | bcast;

    always_comb begin
        state_d = state_q;
        if (is_addr) begin
            state_d = addr_hit ? SELECTED : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign selected = (state_q == SELECTED);

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign pop  = rd_en & ~empty;
    assign push = is_data & selected & (~full | pop);
    assign drop = is_data & selected & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= payload;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
